ring_monitor: RTL and testbench
===============================

RING_MONITOR -- requirements
Module: ring_monitor

Interface
REQ-001 Parameter REV_W, default 8, width of the revolution counter.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset is asserted while low.
REQ-004 ring_in  input  4  one-hot count word from the upstream ring counter.
REQ-005 mode  input  1  expected direction: 1 = right (hot bit moves to lower index, 0 wraps to 3), 0 = left (hot bit moves to higher index, 3 wraps to 0).
REQ-006 clear  input  1  synchronous clear of monitor state.
REQ-007 position  output  2  index of the hot bit in the last valid sample.
REQ-008 valid  output  1  last sample was exactly one-hot.
REQ-009 locked  output  1  high in state LOCKED.
REQ-010 step_err  output  1  one-cycle pulse on a detected fault.
REQ-011 err_sticky  output  1  set on any fault; held until clear or reset.
REQ-012 rev_pulse  output  1  one-cycle pulse on each legal wrap.
REQ-013 rev_count  output  REV_W  count of legal wraps.

Function
REQ-014 The block SHALL register ring_in and mode every cycle as prev_ring and prev_mode; all outputs SHALL be registered with 1-cycle latency from the ring_in sample.
REQ-015 A sample SHALL be one-hot iff exactly one of its 4 bits is 1; valid SHALL equal that test on the current sample.
REQ-016 position SHALL update only on a one-hot sample and hold otherwise.
REQ-017 succ(x) SHALL be {x[0],x[3:1]} when mode=1 and {x[2:0],x[3]} when mode=0.
REQ-018 A step SHALL be legal iff the current sample is one-hot and equals either prev_ring (hold) or succ(prev_ring).
REQ-019 States SHALL be UNLOCKED, LOCKED and FAULT.
REQ-020 UNLOCKED -> LOCKED when the current sample equals succ(prev_ring), both are one-hot, and mode==prev_mode; holds do not lock.
REQ-021 LOCKED stays LOCKED on a legal step.
REQ-022 LOCKED -> FAULT on a non-one-hot sample or a non-hold, non-successor sample, including a reverse step and a 2-position jump.
REQ-023 The LOCKED -> FAULT transition SHALL pulse step_err for 1 cycle and set err_sticky.
REQ-024 A mode change (mode!=prev_mode) in LOCKED SHALL move to UNLOCKED with no error and no rev_pulse.
REQ-025 Errors in UNLOCKED SHALL NOT flag step_err or err_sticky.
REQ-026 FAULT SHALL hold until clear=1; clear=1 in any state SHALL force UNLOCKED, rev_count=0 and err_sticky=0 on the next edge.
REQ-027 clear SHALL win over a simultaneous fault, wrap or lock event.
REQ-028 The wrap SHALL be the step 0001->1000 when mode=1 and 1000->0001 when mode=0.
REQ-029 Only a legal wrap in LOCKED SHALL pulse rev_pulse and increment rev_count.
REQ-030 rev_count SHALL saturate at 2^REV_W-1; rev_pulse still fires at saturation.

Reset
REQ-031 While reset=0: state=UNLOCKED, prev_ring=0000, prev_mode=0, position=0, valid=0, locked=0, step_err=0, err_sticky=0, rev_pulse=0, rev_count=0.
REQ-032 Reset assertion SHALL take effect immediately, with no clock edge required, including mid-revolution or in FAULT; after release the block SHALL relock per REQ-020.

Verification
REQ-033 mode=1, ring_in 0001,1000,0100,0010,0001 -> locked=1 from the 2nd output cycle; rev_pulse exactly once, on the 0001->1000 step; rev_count=1; step_err never 1.
REQ-034 Locked, mode=0, ring_in 0010 then 1000 -> step_err pulses 1 cycle, err_sticky=1, locked=0; state stays FAULT until clear=1, then err_sticky=0 and rev_count=0.
REQ-035 Locked, ring_in=0011 -> valid=0, position unchanged, step_err=1; same stimulus while UNLOCKED -> step_err=0, err_sticky=0.
REQ-036 Locked, mode toggles 1->0 -> locked=0 with no error; 0001,0010 with mode=0 -> relocks.
REQ-037 REV_W=2, 5 legal wraps -> rev_count=3 after the 3rd wrap and stays 3; 5 rev_pulses.
REQ-038 reset driven low between clock edges while locked with rev_count=2 -> all outputs 0 immediately; a fault and clear in the same cycle -> UNLOCKED, err_sticky=0.

Source files
------------

// File: rtl/ring_monitor.sv
// Checks a 4-bit one-hot ring counter for legal steps, locks onto it and counts wraps.
// All outputs are registered one cycle after the sample; there is no backpressure and every cycle is sampled.
module ring_monitor #(
  parameter int REV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       ring_in,
  input  logic             mode,
  input  logic             clear,
  output logic [1:0]       position,
  output logic             valid,
  output logic             locked,
  output logic             step_err,
  output logic             err_sticky,
  output logic             rev_pulse,
  output logic [REV_W-1:0] rev_count
);

  typedef enum logic [1:0] {UNLOCKED, LOCKED, FAULT} state_t;

  state_t     state;
  logic [3:0] prev_ring;
  logic       prev_mode;

  logic [3:0] succ;
  logic [1:0] hot_idx;
  logic       cur_hot;
  logic       prev_hot;
  logic       same_mode;
  logic       is_hold;
  logic       is_succ;
  logic       step_ok;
  logic       is_wrap;
  logic       lock_evt;
  logic       wrap_evt;

  always_comb begin
    succ      = mode ? {prev_ring[0], prev_ring[3:1]} : {prev_ring[2:0], prev_ring[3]};
    cur_hot   = $onehot(ring_in);
    prev_hot  = $onehot(prev_ring);
    same_mode = (mode == prev_mode);
    is_hold   = (ring_in == prev_ring);
    is_succ   = (ring_in == succ);
    step_ok   = cur_hot && (is_hold || is_succ);
    is_wrap   = mode ? (prev_ring == 4'b0001 && ring_in == 4'b1000)
                     : (prev_ring == 4'b1000 && ring_in == 4'b0001);
    lock_evt  = cur_hot && prev_hot && is_succ && same_mode;
    // The step that acquires lock counts as a revolution when it is itself the wrap.
    wrap_evt  = !clear && is_wrap &&
                ((state == UNLOCKED && lock_evt) || (state == LOCKED && same_mode));
  end

  always_comb begin
    hot_idx = 2'd0;
    case (ring_in)
      4'b0010: hot_idx = 2'd1;
      4'b0100: hot_idx = 2'd2;
      4'b1000: hot_idx = 2'd3;
      default: hot_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= UNLOCKED;
      prev_ring  <= 4'b0000;
      prev_mode  <= 1'b0;
      position   <= 2'd0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
      rev_pulse  <= 1'b0;
      rev_count  <= '0;
    end else begin
      prev_ring <= ring_in;
      prev_mode <= mode;
      valid     <= cur_hot;
      if (cur_hot) position <= hot_idx;
      step_err  <= 1'b0;
      rev_pulse <= wrap_evt;
      if (wrap_evt && !(&rev_count))
        rev_count <= rev_count + {{(REV_W-1){1'b0}}, 1'b1};

      if (clear) begin
        state      <= UNLOCKED;
        locked     <= 1'b0;
        err_sticky <= 1'b0;
        rev_count  <= '0;
      end else begin
        case (state)
          UNLOCKED: begin
            if (lock_evt) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            // A direction change is a reconfiguration, not a fault.
            if (!same_mode) begin
              state  <= UNLOCKED;
              locked <= 1'b0;
            end else if (!step_ok) begin
              state      <= FAULT;
              locked     <= 1'b0;
              step_err   <= 1'b1;
              err_sticky <= 1'b1;
            end
          end
          FAULT: begin
            locked <= 1'b0;
          end
          default: begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Directed vector bench for ring_monitor: table of steps plus saturation and async-reset sequences.
module tb_ring_monitor;

  logic       clock;
  logic       reset;
  logic [3:0] ring_in;
  logic       mode;
  logic       clear;

  logic [1:0] position, position2;
  logic       valid, valid2;
  logic       locked, locked2;
  logic       step_err, step_err2;
  logic       err_sticky, err_sticky2;
  logic       rev_pulse, rev_pulse2;
  logic [7:0] rev_count;
  logic [1:0] rev_count2;

  int checks = 0;
  int errors = 0;

  ring_monitor #(.REV_W(8)) dut (
    .clock(clock), .reset(reset), .ring_in(ring_in), .mode(mode), .clear(clear),
    .position(position), .valid(valid), .locked(locked), .step_err(step_err),
    .err_sticky(err_sticky), .rev_pulse(rev_pulse), .rev_count(rev_count)
  );

  ring_monitor #(.REV_W(2)) dut2 (
    .clock(clock), .reset(reset), .ring_in(ring_in), .mode(mode), .clear(clear),
    .position(position2), .valid(valid2), .locked(locked2), .step_err(step_err2),
    .err_sticky(err_sticky2), .rev_pulse(rev_pulse2), .rev_count(rev_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] ring;
    logic       md;
    logic       clr;
    logic       v;
    logic [1:0] pos;
    logic       lk;
    logic       se;
    logic       st;
    logic       rp;
    logic [7:0] cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [3:0] ring, input logic md, input logic clr,
                              input logic v, input logic [1:0] pos, input logic lk,
                              input logic se, input logic st, input logic rp,
                              input logic [7:0] cnt);
    vec_t r;
    r.ring = ring; r.md = md; r.clr = clr; r.v = v; r.pos = pos; r.lk = lk;
    r.se = se; r.st = st; r.rp = rp; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic m, input logic c);
    ring_in = r;
    mode    = m;
    clear   = c;
    @(posedge clock);
    #1;
  endtask

  int pulses;
  logic [3:0] rk;
  logic       wrp;
  int         wraps;

  initial begin
    //             ring     md clr  v  pos  lk se st rp cnt
    vt[0]  = mk(4'b0001, 1, 0,   1, 2'd0, 0, 0, 0, 0, 8'd0);
    vt[1]  = mk(4'b1000, 1, 0,   1, 2'd3, 1, 0, 0, 1, 8'd1);
    vt[2]  = mk(4'b0100, 1, 0,   1, 2'd2, 1, 0, 0, 0, 8'd1);
    vt[3]  = mk(4'b0010, 1, 0,   1, 2'd1, 1, 0, 0, 0, 8'd1);
    vt[4]  = mk(4'b0001, 1, 0,   1, 2'd0, 1, 0, 0, 0, 8'd1);
    vt[5]  = mk(4'b0001, 1, 0,   1, 2'd0, 1, 0, 0, 0, 8'd1);
    vt[6]  = mk(4'b0011, 1, 0,   0, 2'd0, 0, 1, 1, 0, 8'd1);
    vt[7]  = mk(4'b0010, 1, 0,   1, 2'd1, 0, 0, 1, 0, 8'd1);
    vt[8]  = mk(4'b0010, 1, 1,   1, 2'd1, 0, 0, 0, 0, 8'd0);
    vt[9]  = mk(4'b0011, 1, 0,   0, 2'd1, 0, 0, 0, 0, 8'd0);
    vt[10] = mk(4'b0001, 1, 0,   1, 2'd0, 0, 0, 0, 0, 8'd0);
    vt[11] = mk(4'b1000, 1, 0,   1, 2'd3, 1, 0, 0, 1, 8'd1);
    vt[12] = mk(4'b0100, 1, 0,   1, 2'd2, 1, 0, 0, 0, 8'd1);
    vt[13] = mk(4'b0100, 0, 0,   1, 2'd2, 0, 0, 0, 0, 8'd1);
    vt[14] = mk(4'b0001, 0, 0,   1, 2'd0, 0, 0, 0, 0, 8'd1);
    vt[15] = mk(4'b0010, 0, 0,   1, 2'd1, 1, 0, 0, 0, 8'd1);
    vt[16] = mk(4'b0010, 0, 0,   1, 2'd1, 1, 0, 0, 0, 8'd1);
    vt[17] = mk(4'b1000, 0, 0,   1, 2'd3, 0, 1, 1, 0, 8'd1);
    vt[18] = mk(4'b0100, 0, 0,   1, 2'd2, 0, 0, 1, 0, 8'd1);
    vt[19] = mk(4'b1000, 0, 0,   1, 2'd3, 0, 0, 1, 0, 8'd1);
    vt[20] = mk(4'b1000, 0, 1,   1, 2'd3, 0, 0, 0, 0, 8'd0);
    vt[21] = mk(4'b0001, 0, 0,   1, 2'd0, 1, 0, 0, 1, 8'd1);
    vt[22] = mk(4'b1000, 0, 1,   1, 2'd3, 0, 0, 0, 0, 8'd0);
    vt[23] = mk(4'b0001, 0, 0,   1, 2'd0, 1, 0, 0, 1, 8'd1);
    vt[24] = mk(4'b0010, 0, 1,   1, 2'd1, 0, 0, 0, 0, 8'd0);
    vt[25] = mk(4'b0100, 0, 0,   1, 2'd2, 1, 0, 0, 0, 8'd0);
    vt[26] = mk(4'b0010, 0, 0,   1, 2'd1, 0, 1, 1, 0, 8'd0);
    vt[27] = mk(4'b0010, 0, 1,   1, 2'd1, 0, 0, 0, 0, 8'd0);

    reset   = 1'b0;
    ring_in = 4'b0000;
    mode    = 1'b0;
    clear   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_valid",  32'(valid), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_pos",    32'(position), 32'd0);
    chk("reset_sticky", 32'(err_sticky), 32'd0);
    chk("reset_count",  32'(rev_count), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vt[i].ring, vt[i].md, vt[i].clr);
      chk($sformatf("v%0d_valid", i),  32'(valid),      32'(vt[i].v));
      chk($sformatf("v%0d_pos", i),    32'(position),   32'(vt[i].pos));
      chk($sformatf("v%0d_locked", i), 32'(locked),     32'(vt[i].lk));
      chk($sformatf("v%0d_steperr", i),32'(step_err),   32'(vt[i].se));
      chk($sformatf("v%0d_sticky", i), 32'(err_sticky), 32'(vt[i].st));
      chk($sformatf("v%0d_pulse", i),  32'(rev_pulse),  32'(vt[i].rp));
      chk($sformatf("v%0d_count", i),  32'(rev_count),  32'(vt[i].cnt));
      chk($sformatf("v%0d_count2", i), 32'(rev_count2), 32'(vt[i].cnt));
    end

    // Saturation: left rotation starting from prev=0010, wraps on every 1000->0001.
    pulses = 0;
    wraps  = 0;
    for (int k = 0; k < 20; k++) begin
      rk  = 4'b0001 << ((k + 2) % 4);
      wrp = (rk == 4'b0001);
      if (wrp) wraps++;
      step(rk, 1'b0, 1'b0);
      if (rev_pulse2) pulses++;
      chk($sformatf("sat%0d_locked", k), 32'(locked2), 32'd1);
      chk($sformatf("sat%0d_pulse", k),  32'(rev_pulse2), 32'(wrp));
      chk($sformatf("sat%0d_count2", k), 32'(rev_count2), 32'((wraps > 3) ? 3 : wraps));
      chk($sformatf("sat%0d_count8", k), 32'(rev_count), 32'(wraps));
    end
    chk("sat_total_pulses", 32'(pulses), 32'd5);

    // Two wraps after a clear, then reset asserted between clock edges.
    step(4'b0100, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    chk("pre_rst_count",  32'(rev_count), 32'd2);
    chk("pre_rst_pulse",  32'(rev_pulse), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_locked", 32'(locked), 32'd0);
    chk("async_count",  32'(rev_count), 32'd0);
    chk("async_pulse",  32'(rev_pulse), 32'd0);
    chk("async_valid",  32'(valid), 32'd0);
    chk("async_pos",    32'(position), 32'd0);
    #1;
    reset = 1'b1;
    step(4'b0001, 1'b0, 1'b0);
    chk("relock_first", 32'(locked), 32'd0);
    step(4'b0010, 1'b0, 1'b0);
    chk("relock_second", 32'(locked), 32'd1);
    chk("relock_count",  32'(rev_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
